// File: rtl/seg_scan_reader.sv
// seg_scan_reader: recovers the hex value shown on a time-multiplexed,
// active-low seven-segment bus (segments + anode selects).
// Each digit pattern must hold steady before it is accepted.
// A full scan frame is published on value/digit_err with a one-cycle
// frame_valid strobe.
// Optional build macro: SEG_DP_EN adds the decimal-point input dp_in and
// the per-digit output dp_out.
// dbgState exposes the frame FSM state (0=IDLE, 1=COLLECT, 2=DONE).
module seg_scan_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
`ifdef SEG_DP_EN
  input  logic                  dp_in,
`endif
  output logic [4*DIGITS-1:0]   value,
  output logic                  frame_valid,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  err,
`ifdef SEG_DP_EN
  output logic [DIGITS-1:0]     dp_out,
`endif
  output logic [1:0]            dbgState
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_HIT = CW'(STABLE_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

`ifdef SEG_DP_EN
  localparam int W = DIGITS + 8;
`else
  localparam int W = DIGITS + 7;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t              state;
  logic [W-1:0]        rawWord;
  logic [W-1:0]        sync1;
  logic [W-1:0]        sync2;
  logic [CW-1:0]       stableCnt;
  logic [CW-1:0]       cntNext;
  logic [DIGITS-1:0]   curAn;
  logic [6:0]          curSeg;
  logic [3:0]          lowCnt;
  logic [IW-1:0]       capIdx;
  logic                capture;
  logic [4:0]          capDec;
  logic [IW-1:0]       expIdx;
  logic [4*DIGITS-1:0] shadowVal;
  logic [DIGITS-1:0]   shadowErr;
`ifdef SEG_DP_EN
  logic                curDp;
  logic [DIGITS-1:0]   shadowDp;
`endif

  // Active-low pattern (g..a) to {bad, nibble}; unknown patterns give nibble 0.
  function automatic logic [4:0] decodeSeg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = 5'h00;
      7'b1111001: r = 5'h01;
      7'b0100100: r = 5'h02;
      7'b0110000: r = 5'h03;
      7'b0011001: r = 5'h04;
      7'b0010010: r = 5'h05;
      7'b0000010: r = 5'h06;
      7'b1111000: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0010000: r = 5'h09;
      7'b0001000: r = 5'h0A;
      7'b0000011: r = 5'h0B;
      7'b1000110: r = 5'h0C;
      7'b0100001: r = 5'h0D;
      7'b0000110: r = 5'h0E;
      7'b0001110: r = 5'h0F;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

`ifdef SEG_DP_EN
  assign rawWord = {dp_in, an_in, seg_in};
  assign curDp   = sync1[W-1];
`else
  assign rawWord = {an_in, seg_in};
`endif

  // The word entering the second synchronizer stage is the one judged this edge.
  assign curAn  = sync1[7 +: DIGITS];
  assign curSeg = sync1[6:0];
  assign dbgState = state;

  // Two-flop synchronizer; idle bus (all ones) means blank and no digit selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= rawWord;
      sync2 <= sync1;
    end
  end

  // Next stability count: clears on any word change, otherwise saturating
  // increment so a long dwell passes the capture threshold exactly once.
  always_comb begin
    cntNext = '0;
    if (sync1 == sync2) begin
      if (stableCnt == CNT_SAT) cntNext = CNT_SAT;
      else                      cntNext = stableCnt + 1'b1;
    end
  end

  // Stability counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stableCnt <= '0;
    else        stableCnt <= cntNext;
  end

  // Anode decode: count low selects and remember which one is low.
  always_comb begin
    lowCnt = '0;
    capIdx = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (!curAn[k]) begin
        lowCnt = lowCnt + 1'b1;
        capIdx = IW'(k);
      end
    end
  end

  assign capture = (lowCnt == 4'd1) && (cntNext == CNT_HIT);
  assign capDec  = decodeSeg(curSeg);

  // Frame assembly FSM: shadow slots fill in digit order, published in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      expIdx      <= '0;
      shadowVal   <= '0;
      shadowErr   <= '0;
      value       <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
`ifdef SEG_DP_EN
      shadowDp    <= '0;
      dp_out      <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      err         <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (state == DONE) begin
            value       <= shadowVal;
            digit_err   <= shadowErr;
            frame_valid <= 1'b1;
            err         <= |shadowErr;
`ifdef SEG_DP_EN
            dp_out      <= shadowDp;
`endif
          end
          state <= IDLE;
          if (capture && (capIdx == '0)) begin
            shadowVal[{capIdx, 2'b00} +: 4] <= capDec[3:0];
            shadowErr[capIdx]               <= capDec[4];
`ifdef SEG_DP_EN
            shadowDp[capIdx]                <= ~curDp;
`endif
            if (DIGITS == 1) begin
              state <= DONE;
            end else begin
              expIdx <= IW'(1);
              state  <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (capture) begin
            if (capIdx == expIdx) begin
              shadowVal[{capIdx, 2'b00} +: 4] <= capDec[3:0];
              shadowErr[capIdx]               <= capDec[4];
`ifdef SEG_DP_EN
              shadowDp[capIdx]                <= ~curDp;
`endif
              if (expIdx == LAST_IDX) state  <= DONE;
              else                    expIdx <= expIdx + 1'b1;
            end else begin
              // Out-of-order digit: abort the partial frame.
              err <= 1'b1;
              if (capIdx == '0) begin
                shadowVal[{capIdx, 2'b00} +: 4] <= capDec[3:0];
                shadowErr[capIdx]               <= capDec[4];
`ifdef SEG_DP_EN
                shadowDp[capIdx]                <= ~curDp;
`endif
                expIdx <= IW'(1);
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seg_scan_reader.md
# seg_scan_reader

Receive side of the seven-segment display interface: observes a time-multiplexed, active-low, multi-digit seven-segment bus (segment lines plus anode selects) and recovers the hexadecimal value being shown. Each digit pattern must be stable before it is accepted. A full scan frame is assembled into a parallel word with a one-cycle valid strobe. Used as a loopback checker for display drivers and to read displays driven by external boards.

## Interface
- `DIGITS`, default 4: number of multiplexed digits; legal range 1..8.
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a digit is accepted; minimum 1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `seg_in`  in  7  segment lines, active-low; bit0=a … bit6=g (so `7'b1000000` is "0"); asynchronous to `clk`.
- `an_in`  in  DIGITS  digit selects, active-low, one-hot-low when valid; bit0 = digit 0; asynchronous.
- `value`  out  4*DIGITS  last complete frame; digit k in bits [4k+3:4k].
- `frame_valid`  out  1  one-cycle pulse when `value` updates.
- `digit_err`  out  DIGITS  per-digit undecodable flag for the last frame.
- `err`  out  1  one-cycle pulse, concurrent with `frame_valid`, equal to OR of `digit_err`; also pulses on a frame abort.

## Operation
- Input conditioning: `{an_in, seg_in}` passes through a 2-flop synchronizer; all flops reset to all-ones (blank, no digit).
- Stability: `stable_cnt` clears whenever the synchronized word differs from the previous cycle, otherwise increments, saturating. A digit is captured once per dwell, on the cycle where the word has been identical for STABLE_CYCLES consecutive clocks and `an` has exactly one bit low. Further identical cycles do not re-capture.
- `an` all-high or more than one bit low: no capture; the stability counter still runs.
- Decode (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Any other pattern, including blank 1111111, decodes to nibble 0 and sets that digit's error bit.
- FSM:
  - IDLE: wait for a capture of digit 0, then write slot 0, set `exp`=1 and go to COLLECT. If DIGITS=1, go to DONE instead.
  - COLLECT: a capture of digit `exp` writes the slot and increments `exp`. After capturing digit DIGITS-1, go to DONE.
  - COLLECT, out-of-order capture: pulse `err`, discard the partial frame (`value`/`digit_err` unchanged). If the captured digit is 0, restart COLLECT with it in slot 0; otherwise go to IDLE.
  - DONE: copy shadow slots to `value`/`digit_err`, pulse `frame_valid` (and `err` if any digit bad), go to IDLE. A capture arriving in DONE is processed as in IDLE.
- `value` and `digit_err` change only in DONE. Partial frames are never visible.

## Timing
- Reset values: `value`=0, `frame_valid`=0, `digit_err`=0, `err`=0, FSM=IDLE, `stable_cnt`=0, shadow slots=0.
- Input change at edge t is visible at the synchronizer output at edge t+2. Capture occurs at edge t+2+STABLE_CYCLES-1.
- `frame_valid` is registered and high for exactly the cycle after the final digit capture.
- Reset asserted mid-frame: all state clears immediately. The first frame after release must start from a fresh digit-0 capture.
- Minimum digit dwell for acceptance: STABLE_CYCLES+1 clocks, which allows for the synchronizer skew between `an` and `seg` settling.

## Configuration
- `SEG_DP_EN` defined:
  - Adds input `dp_in` (1 bit, active-low, synchronized with the bus and included in the stability compare).
  - Adds output `dp_out` (DIGITS bits, reset 0, updated in DONE).
- `SEG_DP_EN` undefined: neither port exists; decimal point is ignored.

## Test plan
- Scan digits 0..3 showing 1,2,3,4 (1111001, 0100100, 0110000, 0011001), each held 10 clocks → `value`=16'h4321, `frame_valid` one pulse, `err`=0, `digit_err`=0.
- Same scan with STABLE_CYCLES=4 and digit 2 held only 3 clocks → no frame_valid for that scan. The next good scan yields 16'h4321.
- Digit 1 shows 1111111 (blank) → `value`=16'h4301, `digit_err`=4'b0010, `err` pulse with `frame_valid`.
- Scan order 0,2,… → `err` pulse at the digit-2 capture, `value` unchanged. The next in-order frame updates normally.
- `an_in`=4'b1100 with a valid pattern for 20 clocks → no capture, no pulses. Reset mid-frame after digits 0,1 → outputs zero and the next full frame decodes correctly.
- With `SEG_DP_EN`: dp low on digit 3 only → `dp_out`=4'b1000 at `frame_valid`.
